// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ==========================================================================
// hazard_stall_unit : stall/flush control for load-use, dmem waits, branches
// Rev 1.0
// ==========================================================================
module hazard_stall_unit #(
    parameter int LOAD_USE_STALL = 1,
    parameter int TIMEOUT        = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_inst,
    input  logic             id_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_we_reg,
    input  logic             ex_re_mem,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] C_ST_RUN      = 2'd0;
    localparam logic [1:0] C_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] C_ST_ERROR    = 2'd2;

    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OP_OP     = 7'b0110011;
    localparam logic [6:0] C_OP_OP32   = 7'b0111011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;

    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_rs1_used;
    logic       w_rs2_used;
    logic       w_load_use;
    logic       w_mem_busy;
    logic [1:0] w_state_eff;
    logic       w_unused_inst;

    assign w_opcode = id_inst[6:0];
    assign w_rs1    = id_inst[19:15];
    assign w_rs2    = id_inst[24:20];

    assign w_unused_inst = ^{id_inst[31:25], id_inst[14:7]};

    assign w_rs1_used = (w_opcode != C_OP_JAL) && (w_opcode != C_OP_LUI) &&
                        (w_opcode != C_OP_AUIPC);
    assign w_rs2_used = (w_opcode == C_OP_OP) || (w_opcode == C_OP_OP32) ||
                        (w_opcode == C_OP_BRANCH) || (w_opcode == C_OP_STORE);

    assign w_load_use = (LOAD_USE_STALL != 0) && id_valid && ex_re_mem && ex_we_reg &&
                        (ex_rd != 5'd0) &&
                        ((w_rs1_used && (w_rs1 == ex_rd)) ||
                         (w_rs2_used && (w_rs2 == ex_rd)));

    assign w_mem_busy = dmem_req && !dmem_ack;

    // Outputs behave as in RUN while reset is held, whatever the stored state.
    assign w_state_eff = rst ? C_ST_RUN : state_q;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            C_ST_RUN: begin
                wait_cnt_d = '0;
                if (w_mem_busy) begin
                    state_d = C_ST_MEM_WAIT;
                end
            end
            C_ST_MEM_WAIT: begin
                if (dmem_ack) begin
                    state_d    = C_ST_RUN;
                    wait_cnt_d = '0;
                end else if (w_mem_busy) begin
                    if (wait_cnt_q == C_WAIT_LAST) begin
                        state_d       = C_ST_ERROR;
                        mem_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            C_ST_ERROR: begin
                mem_timeout_d = 1'b1;
            end
            default: begin
                state_d    = C_ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idex_stall   = 1'b0;
        exmem_stall  = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (w_state_eff == C_ST_ERROR) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (w_mem_busy) begin
            // EX is frozen here, so a pending redirect is taken on the release cycle.
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= C_ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ==========================================================================
// tb_hazard_stall_unit : scoreboard bench for hazard_stall_unit
// Rev 1.0
// ==========================================================================
module tb_hazard_stall_unit;

    localparam int CW = 8;

    // Output vector order: pc, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, bubble, timeout
    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_MEM  = 8'b1111_0010;
    localparam logic [7:0] E_BR   = 8'b0000_1100;
    localparam logic [7:0] E_LU   = 8'b1100_0100;
    localparam logic [7:0] E_ERR  = 8'b1111_0011;

    localparam logic [31:0] ADD_X6_X5_X7  = {7'b0, 5'd7, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] SD_X5_X8      = {7'b0, 5'd5, 5'd8, 3'b011, 5'd0, 7'b0100011};
    localparam logic [31:0] LUI_X5_R5     = {7'b0, 5'd0, 5'd5, 3'b000, 5'd5, 7'b0110111};
    localparam logic [31:0] ADDI_X6_X0_1  = {12'd1, 5'd0, 3'b000, 5'd6, 7'b0010011};
    localparam logic [31:0] ADDI_X6_X8_5  = {12'd5, 5'd8, 3'b000, 5'd6, 7'b0010011};
    localparam logic [31:0] ADDI_X6_X5_1  = {12'd1, 5'd5, 3'b000, 5'd6, 7'b0010011};
    localparam logic [31:0] JAL_X1_R5     = {12'd0, 5'd5, 3'b000, 5'd1, 7'b1101111};
    localparam logic [31:0] AUIPC_X1_R5   = {12'd0, 5'd5, 3'b000, 5'd1, 7'b0010111};
    localparam logic [31:0] BEQ_X1_X5     = {7'b0, 5'd5, 5'd1, 3'b000, 5'd0, 7'b1100011};
    localparam logic [31:0] ADDW_X6_X3_X5 = {7'b0, 5'd5, 5'd3, 3'b000, 5'd6, 7'b0111011};
    localparam logic [31:0] LD_X6_X5      = {12'd0, 5'd5, 3'b011, 5'd6, 7'b0000011};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   id_inst = '0;
    logic          id_valid = 1'b0;
    logic [4:0]    ex_rd = '0;
    logic          ex_we_reg = 1'b0;
    logic          ex_re_mem = 1'b0;
    logic          branch_taken = 1'b0;
    logic          dmem_req = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic          ifid_flush, idex_flush, memwb_bubble, mem_timeout;
    logic [CW-1:0] stall_cycles;
    logic [7:0]    outs;

    logic [7:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign outs = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                   ifid_flush, idex_flush, memwb_bubble, mem_timeout};

    hazard_stall_unit #(
        .LOAD_USE_STALL(1),
        .TIMEOUT       (255),
        .CNT_W         (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .ex_rd       (ex_rd),
        .ex_we_reg   (ex_we_reg),
        .ex_re_mem   (ex_re_mem),
        .branch_taken(branch_taken),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .idex_stall  (idex_stall),
        .exmem_stall (exmem_stall),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .memwb_bubble(memwb_bubble),
        .mem_timeout (mem_timeout),
        .stall_cycles(stall_cycles)
    );

    task automatic drive_pipe(input logic [31:0] inst, input logic valid,
                              input logic [4:0] rd, input logic re, input logic we);
        id_inst   = inst;
        id_valid  = valid;
        ex_rd     = rd;
        ex_re_mem = re;
        ex_we_reg = we;
    endtask

    task automatic set_idle();
        drive_pipe('0, 1'b0, 5'd0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        dmem_req     = 1'b0;
        dmem_ack     = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] want;
        apply_reset();
        @(negedge clk);
        exp_q.push_back(E_NONE);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (outs !== want) begin
            errors++;
            $display("FAIL reset_outputs: outputs=%b expected=%b", outs, want);
        end
        checks++;
        if (stall_cycles !== '0) begin
            errors++;
            $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles);
        end
    endtask

    task automatic test_load_use();
        logic [7:0] want;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            case (i)
                0: begin drive_pipe(ADD_X6_X5_X7, 1'b1, 5'd5, 1'b1, 1'b1); exp_q.push_back(E_LU); end
                1: begin drive_pipe(ADD_X6_X5_X7, 1'b1, 5'd0, 1'b0, 1'b0); exp_q.push_back(E_NONE); end
                2: begin drive_pipe(SD_X5_X8, 1'b1, 5'd5, 1'b1, 1'b1); exp_q.push_back(E_LU); end
                default: begin drive_pipe(SD_X5_X8, 1'b1, 5'd0, 1'b0, 1'b0); exp_q.push_back(E_NONE); end
            endcase
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL load_use[%0d]: outputs=%b expected=%b", i, outs, want);
            end
            if (i == 1) begin
                checks++;
                if (stall_cycles !== 8'd1) begin
                    errors++;
                    $display("FAIL load_use_count: got %0d expected 1", stall_cycles);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_no_false_hazard();
        logic [7:0] want;
        int n_lu = 0;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            case (i)
                0:  begin drive_pipe(LUI_X5_R5,     1'b1, 5'd5, 1'b1, 1'b1); want = E_NONE; end
                1:  begin drive_pipe(ADDI_X6_X0_1,  1'b1, 5'd0, 1'b1, 1'b1); want = E_NONE; end
                2:  begin drive_pipe(ADDI_X6_X8_5,  1'b1, 5'd5, 1'b1, 1'b1); want = E_NONE; end
                3:  begin drive_pipe(ADD_X6_X5_X7,  1'b0, 5'd5, 1'b1, 1'b1); want = E_NONE; end
                4:  begin drive_pipe(ADD_X6_X5_X7,  1'b1, 5'd5, 1'b0, 1'b1); want = E_NONE; end
                5:  begin drive_pipe(JAL_X1_R5,     1'b1, 5'd5, 1'b1, 1'b1); want = E_NONE; end
                6:  begin drive_pipe(AUIPC_X1_R5,   1'b1, 5'd5, 1'b1, 1'b1); want = E_NONE; end
                7:  begin drive_pipe(BEQ_X1_X5,     1'b1, 5'd5, 1'b1, 1'b1); want = E_LU;   end
                8:  begin drive_pipe(ADDW_X6_X3_X5, 1'b1, 5'd5, 1'b1, 1'b1); want = E_LU;   end
                9:  begin drive_pipe(LD_X6_X5,      1'b1, 5'd5, 1'b1, 1'b1); want = E_LU;   end
                10: begin drive_pipe(ADDI_X6_X5_1,  1'b1, 5'd5, 1'b1, 1'b1); want = E_LU;   end
                default: begin drive_pipe(ADD_X6_X5_X7, 1'b1, 5'd5, 1'b1, 1'b0); want = E_NONE; end
            endcase
            exp_q.push_back(want);
            if (want[7]) n_lu++;
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL decode[%0d]: outputs=%b expected=%b", i, outs, want);
            end
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (stall_cycles !== CW'(n_lu)) begin
            errors++;
            $display("FAIL decode_count: got %0d expected %0d", stall_cycles, n_lu);
        end
    endtask

    task automatic test_mem_wait();
        logic [7:0] want;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dmem_req = (i < 5);
            dmem_ack = (i == 4);
            exp_q.push_back((i < 4) ? E_MEM : E_NONE);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL mem_wait[%0d]: outputs=%b expected=%b", i, outs, want);
            end
        end
        checks++;
        if (stall_cycles !== 8'd4) begin
            errors++;
            $display("FAIL mem_wait_count: got %0d expected 4", stall_cycles);
        end
        set_idle();
    endtask

    task automatic test_branch_wait();
        logic [7:0] want;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            branch_taken = (i < 4);
            dmem_req     = (i < 4);
            dmem_ack     = (i == 3);
            exp_q.push_back((i < 3) ? E_MEM : ((i == 3) ? E_BR : E_NONE));
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL branch_wait[%0d]: outputs=%b expected=%b", i, outs, want);
            end
        end
        set_idle();
    endtask

    task automatic test_branch_load_use();
        logic [7:0] want;
        apply_reset();
        @(negedge clk);
        drive_pipe(ADD_X6_X5_X7, 1'b1, 5'd5, 1'b1, 1'b1);
        branch_taken = 1'b1;
        exp_q.push_back(E_BR);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (outs !== want) begin
            errors++;
            $display("FAIL branch_load_use: outputs=%b expected=%b", outs, want);
        end
        set_idle();
    endtask

    task automatic test_timeout();
        logic [7:0] want;
        apply_reset();
        // Short wait first: the counter must be clean for the long runs below.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            dmem_req = 1'b1;
            dmem_ack = (i == 10);
        end
        // 1 RUN cycle + 254 MEM_WAIT busy cycles, ack on the 255th MEM_WAIT cycle.
        for (int i = 0; i < 257; i++) begin
            @(negedge clk);
            dmem_req = (i < 256);
            dmem_ack = (i == 255);
            exp_q.push_back((i < 255) ? E_MEM : E_NONE);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL ack_at_limit[%0d]: outputs=%b expected=%b", i, outs, want);
            end
        end
        // No ack: 256 busy cycles, then ERROR, then the request goes away.
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            dmem_req = (i < 257);
            dmem_ack = 1'b0;
            exp_q.push_back((i < 256) ? E_MEM : E_ERR);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL timeout[%0d]: outputs=%b expected=%b", i, outs, want);
            end
        end
        checks++;
        if (stall_cycles !== 8'hFF) begin
            errors++;
            $display("FAIL stall_saturate: got %0d expected 255", stall_cycles);
        end
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        #1;
        checks++;
        if ((outs & 8'hFE) !== 8'h00) begin
            errors++;
            $display("FAIL in_reset_controls: outputs=%b expected=0000000x", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(E_NONE);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (outs !== want) begin
            errors++;
            $display("FAIL after_reset: outputs=%b expected=%b", outs, want);
        end
        checks++;
        if (stall_cycles !== '0) begin
            errors++;
            $display("FAIL after_reset_count: got %0d expected 0", stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_mem_wait();
        test_branch_wait();
        test_branch_load_use();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
